// File: rtl/tartaruga_pkg.sv
// Shared types for the execute-stage latency tracking pipe.
// Slot layout, empty-slot constant and default stage count.
package tartaruga_pkg;

  localparam int MAX_EXE_STAGES = 4;
  localparam int EXE_PAYLOAD_W  = 64;

  typedef struct packed {
    logic                     valid;
    logic                     we;
    logic [4:0]               rd;
    logic [EXE_PAYLOAD_W-1:0] payload;
  } exe_slot_t;

  localparam exe_slot_t EXE_SLOT_EMPTY = '0;

endpackage

// File: rtl/exe_pipe_lookup.sv
// RAW lookup over in-flight slots: rd match plus
// lowest-index priority encode (soonest to retire wins).
module exe_pipe_lookup
  import tartaruga_pkg::*;
#(
  parameter int DEPTH = MAX_EXE_STAGES,
  parameter int LAT_W = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0] i_wr_en,
  input  logic [4:0]       i_rd [DEPTH],
  input  logic [4:0]       i_query_rd,
  output logic             o_hit,
  output logic [LAT_W-1:0] o_lat
);

  // Scan high to low so the lowest matching slot is left in o_lat
  always_comb begin
    o_hit = 1'b0;
    o_lat = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_wr_en[i] && (i_rd[i] == i_query_rd) &&
          (i_query_rd != 5'd0)) begin
        o_hit = 1'b1;
        o_lat = LAT_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/exe_latency_pipe.sv
// Execute-stage tracking pipe for mixed-latency units.
// Optional statistics counters: define EXE_PIPE_STATS_EN.
module exe_latency_pipe
  import tartaruga_pkg::*;
#(
  parameter int DEPTH     = MAX_EXE_STAGES,
  parameter int PAYLOAD_W = EXE_PAYLOAD_W,
  parameter int LAT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LAT_W-1:0]     in_lat_i,
  input  logic                 in_we_i,
  input  logic [4:0]           in_rd_i,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  input  logic                 hold_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  output logic                 out_we_o,
  output logic [4:0]           out_rd_o,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  input  logic [4:0]           query_rd_i,
  output logic                 query_hit_o,
  output logic [LAT_W-1:0]     query_lat_o,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          issue_cnt_o
);

  exe_slot_t        r_slot [DEPTH];
  exe_slot_t        w_nxt  [DEPTH];
  exe_slot_t        w_ins;
  logic             w_lat_ok;
  logic             w_busy;
  logic             w_accept;
  logic [DEPTH-1:0] w_wr_en;
  logic [4:0]       w_rd [DEPTH];

  // Latency legality and landing-slot collision check
  always_comb begin
    w_lat_ok = (in_lat_i != '0) && (in_lat_i <= LAT_W'(DEPTH));
    w_busy   = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (in_lat_i == LAT_W'(i)) begin
        w_busy = r_slot[i].valid;
      end
    end
  end

  assign in_ready_o = ~hold_i & ~flush_i & w_lat_ok & ~w_busy;
  assign w_accept   = in_valid_i & in_ready_o;

  // Build the inserted entry from issue inputs
  always_comb begin
    w_ins         = EXE_SLOT_EMPTY;
    w_ins.valid   = 1'b1;
    w_ins.we      = in_we_i;
    w_ins.rd      = in_rd_i;
    w_ins.payload = EXE_PAYLOAD_W'(in_payload_i);
  end

  // Shift toward slot 0, insertion overrides the shifted value
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_nxt[i] = r_slot[i + 1];
    end
    w_nxt[DEPTH - 1] = EXE_SLOT_EMPTY;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_accept && (in_lat_i == LAT_W'(i + 1))) begin
        w_nxt[i] = w_ins;
      end
    end
  end

  // Slot state: reset/flush clear, hold freezes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= EXE_SLOT_EMPTY;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= EXE_SLOT_EMPTY;
    end else if (!hold_i) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= w_nxt[i];
    end
  end

  assign out_valid_o   = r_slot[0].valid;
  assign out_we_o      = r_slot[0].we;
  assign out_rd_o      = r_slot[0].rd;
  assign out_payload_o = r_slot[0].payload[PAYLOAD_W-1:0];

  // Flatten slot fields needed by the RAW lookup
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wr_en[i] = r_slot[i].valid & r_slot[i].we;
      w_rd[i]    = r_slot[i].rd;
    end
  end

  exe_pipe_lookup #(
    .DEPTH (DEPTH),
    .LAT_W (LAT_W)
  ) u_lookup (
    .i_wr_en    (w_wr_en),
    .i_rd       (w_rd),
    .i_query_rd (query_rd_i),
    .o_hit      (query_hit_o),
    .o_lat      (query_lat_o)
  );

`ifdef EXE_PIPE_STATS_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating issue and stall statistics
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept && (r_issue_cnt != '1)) begin
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
      if (in_valid_i && !in_ready_o && !flush_i &&
          (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign issue_cnt_o = r_issue_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  assign issue_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

  // Decode must never present an out-of-range latency
  a_lat_legal : assert property (
    @(posedge clk_i) disable iff (rst_i)
    in_valid_i |-> w_lat_ok
  ) else $error("illegal exe latency %0d", in_lat_i);

endmodule
